// File: rtl/gb_bus_responder_pkg.sv
// Shared address map, DMA state encoding and interrupt bit indices for the
// sm83 bus responder.
package gb_bus_responder_pkg;

  localparam logic [15:0] HRAM_BASE     = 16'hFF80;
  localparam logic [15:0] HRAM_LAST     = 16'hFFFE;
  localparam logic [15:0] ADDR_IE       = 16'hFFFF;
  localparam logic [15:0] ADDR_IF       = 16'hFF0F;
  localparam logic [15:0] ADDR_DMA      = 16'hFF46;
  localparam logic [15:0] ADDR_BOOT_OFF = 16'hFF50;
  localparam logic [15:0] OAM_BASE      = 16'hFE00;

  localparam int unsigned IRQ_W      = 5;
  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  localparam int unsigned DMA_LEN_DEF   = 160;
  localparam int unsigned BOOT_SIZE_DEF = 256;

  typedef enum logic {
    DMA_IDLE,
    DMA_XFER
  } dma_state_t;

  // Sources at E0 and above alias the echo region back onto WRAM.
  function automatic logic [7:0] dma_src_fix(input logic [7:0] v);
    return (v >= 8'hE0) ? (v & 8'hDF) : v;
  endfunction

endpackage

// File: rtl/gb_bus_responder_oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {src, idx} into OAM, one per cycle.
module oam_dma_m
  import gb_bus_responder_pkg::*;
#(
  parameter int unsigned DMA_LEN = DMA_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_src,
  input  logic [7:0]  ext_rdata,
  output logic [7:0]  dma_reg,
  output logic [15:0] dma_ext_addr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);

  localparam int unsigned IDX_W = 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DMA_LEN - 1);

  dma_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       src_q, src_d;
  logic [7:0]       reg_q, reg_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DMA_IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      reg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      reg_q   <= reg_d;
    end
  end

  // A start during XFER restarts the copy with no idle gap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    reg_d   = reg_q;
    if (start) begin
      state_d = DMA_XFER;
      idx_d   = '0;
      src_d   = dma_src_fix(start_src);
      reg_d   = start_src;
    end else if (state_q == DMA_XFER) begin
      if (idx_q == IDX_LAST) begin
        state_d = DMA_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Gated by rst so that asserting reset mid-transfer stops OAM writes at once.
  assign dma_active   = rst && (state_q == DMA_XFER);
  assign oam_we       = dma_active;
  assign oam_addr     = idx_q;
  assign oam_wdata    = ext_rdata;
  assign dma_ext_addr = {src_q, idx_q};
  assign dma_reg      = reg_q;

endmodule

// File: rtl/gb_bus_responder.sv
// Memory-side responder for the sm83 core: HRAM, IF/IE, boot overlay, OAM DMA,
// with all remaining accesses forwarded to the external port.
module gb_bus_responder
  import gb_bus_responder_pkg::*;
#(
  parameter int unsigned DMA_LEN   = DMA_LEN_DEF,
  parameter int unsigned BOOT_SIZE = BOOT_SIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_wdata,
  input  logic             cpu_write,
  output logic [7:0]       cpu_rdata,
  output logic [15:0]      ext_addr,
  output logic [7:0]       ext_wdata,
  output logic             ext_we,
  input  logic [7:0]       ext_rdata,
  output logic [7:0]       boot_addr,
  input  logic [7:0]       boot_rdata,
  output logic [7:0]       oam_addr,
  output logic [7:0]       oam_wdata,
  output logic             oam_we,
  input  logic [IRQ_W-1:0] irq_req,
  output logic [IRQ_W-1:0] if_q,
  output logic             irq_pending,
  output logic             dma_active
);

  logic [7:0]  ie_q;
  logic        boot_en_q;
  logic [7:0]  hram_q [0:127];
  logic [7:0]  dma_reg;
  logic [15:0] dma_ext_addr;

  logic is_ie, is_hram, is_if, is_dma, is_boff, is_boot, is_int;

  // Address decode in priority order; the boot window only claims reads.
  always_comb begin
    is_ie   = (cpu_addr == ADDR_IE);
    is_hram = !is_ie && (cpu_addr >= HRAM_BASE) && (cpu_addr <= HRAM_LAST);
    is_if   = (cpu_addr == ADDR_IF);
    is_dma  = (cpu_addr == ADDR_DMA);
    is_boff = (cpu_addr == ADDR_BOOT_OFF);
    is_int  = is_ie || is_hram || is_if || is_dma || is_boff;
    is_boot = boot_en_q && (32'(cpu_addr) < BOOT_SIZE);
  end

  always_comb begin
    cpu_rdata = 8'hFF;
    if (is_ie)               cpu_rdata = ie_q;
    else if (is_hram)        cpu_rdata = hram_q[cpu_addr[6:0]];
    else if (is_if)          cpu_rdata = {3'b111, if_q};
    else if (is_dma)         cpu_rdata = dma_reg;
    else if (is_boff)        cpu_rdata = 8'hFF;
    else if (dma_active)     cpu_rdata = 8'hFF;
    else if (is_boot)        cpu_rdata = boot_rdata;
    else                     cpu_rdata = ext_rdata;
  end

  assign ext_addr    = dma_active ? dma_ext_addr : cpu_addr;
  assign ext_wdata   = cpu_wdata;
  assign ext_we      = rst && cpu_write && !is_int && !dma_active;
  assign boot_addr   = cpu_addr[7:0];
  assign irq_pending = |(ie_q[IRQ_W-1:0] & if_q);

  // Interrupt and boot-control registers; a request always survives a CPU write to IF.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_q      <= '0;
      ie_q      <= '0;
      boot_en_q <= 1'b1;
    end else begin
      if_q <= ((cpu_write && is_if) ? cpu_wdata[IRQ_W-1:0] : if_q) | irq_req;
      if (cpu_write && is_ie)
        ie_q <= cpu_wdata;
      if (cpu_write && is_boff && (cpu_wdata != 8'h00))
        boot_en_q <= 1'b0;
    end
  end

  // HRAM keeps its contents across reset; entry 127 is shadowed by IE and never used.
  always_ff @(posedge clk) begin
    if (rst && cpu_write && is_hram)
      hram_q[cpu_addr[6:0]] <= cpu_wdata;
  end

  oam_dma_m #(
    .DMA_LEN (DMA_LEN)
  ) u_dma (
    .clk          (clk),
    .rst          (rst),
    .start        (cpu_write && is_dma),
    .start_src    (cpu_wdata),
    .ext_rdata    (ext_rdata),
    .dma_reg      (dma_reg),
    .dma_ext_addr (dma_ext_addr),
    .oam_addr     (oam_addr),
    .oam_wdata    (oam_wdata),
    .oam_we       (oam_we),
    .dma_active   (dma_active)
  );

endmodule

// File: tb/tb_gb_bus_responder.sv
// Directed bench for gb_bus_responder; expectations go through a FIFO scoreboard.
module tb_gb_bus_responder;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  cpu_rdata;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_we;
  logic [7:0]  ext_rdata;
  logic [7:0]  boot_addr;
  logic [7:0]  boot_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic [4:0]  irq_req;
  logic [4:0]  if_q;
  logic        irq_pending;
  logic        dma_active;

  gb_bus_responder dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_write   (cpu_write),
    .cpu_rdata   (cpu_rdata),
    .ext_addr    (ext_addr),
    .ext_wdata   (ext_wdata),
    .ext_we      (ext_we),
    .ext_rdata   (ext_rdata),
    .boot_addr   (boot_addr),
    .boot_rdata  (boot_rdata),
    .oam_addr    (oam_addr),
    .oam_wdata   (oam_wdata),
    .oam_we      (oam_we),
    .irq_req     (irq_req),
    .if_q        (if_q),
    .irq_pending (irq_pending),
    .dma_active  (dma_active)
  );

  // External memory returns its low address byte; boot ROM returns the inverted address.
  assign ext_rdata  = ext_addr[7:0];
  assign boot_rdata = ~boot_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive one bus cycle at the falling edge and settle before sampling.
  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic w,
                     input logic [4:0] irq);
    @(negedge clk);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = w;
    irq_req   = irq;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst       = 1'b0;
    cpu_addr  = 16'h2000;
    cpu_wdata = 8'h11;
    cpu_write = 1'b1;
    irq_req   = 5'h00;

    // Reset holds write enables low even with a pending external write.
    @(negedge clk); #2;
    push("rst_ext_we", 16'h0);     cmp(16'(ext_we));
    push("rst_oam_we", 16'h0);     cmp(16'(oam_we));
    push("rst_dma_active", 16'h0); cmp(16'(dma_active));
    @(negedge clk);
    rst = 1'b1;

    // Boot overlay.
    bus(16'h0050, 8'h00, 1'b0, 5'h00);
    push("rst_if", 16'h00);        cmp(16'(if_q));
    push("boot_rd", 16'h00AF);     cmp(16'(cpu_rdata));
    bus(16'hFF50, 8'h00, 1'b1, 5'h00);
    push("ff50_ext_we", 16'h0);    cmp(16'(ext_we));
    bus(16'h0050, 8'h00, 1'b0, 5'h00);
    push("boot_keep", 16'h00AF);   cmp(16'(cpu_rdata));
    bus(16'hFF50, 8'h00, 1'b0, 5'h00);
    push("ff50_rd", 16'h00FF);     cmp(16'(cpu_rdata));
    bus(16'hFF50, 8'h01, 1'b1, 5'h00);
    bus(16'h0050, 8'h00, 1'b0, 5'h00);
    push("boot_off_rd", 16'h0050); cmp(16'(cpu_rdata));

    // HRAM and IE.
    bus(16'hFF80, 8'h5A, 1'b1, 5'h00);
    push("hram_lo_we", 16'h0);     cmp(16'(ext_we));
    bus(16'hFFFE, 8'hA5, 1'b1, 5'h00);
    push("hram_hi_we", 16'h0);     cmp(16'(ext_we));
    bus(16'hFFFF, 8'h1F, 1'b1, 5'h00);
    push("ie_we", 16'h0);          cmp(16'(ext_we));
    bus(16'hFF80, 8'h00, 1'b0, 5'h00);
    push("hram_lo_rd", 16'h005A);  cmp(16'(cpu_rdata));
    bus(16'hFFFE, 8'h00, 1'b0, 5'h00);
    push("hram_hi_rd", 16'h00A5);  cmp(16'(cpu_rdata));
    bus(16'hFFFF, 8'h00, 1'b0, 5'h00);
    push("ie_rd", 16'h001F);       cmp(16'(cpu_rdata));

    // Interrupt request and IF write race.
    bus(16'h0000, 8'h00, 1'b0, 5'h04);
    bus(16'hFF0F, 8'h00, 1'b0, 5'h00);
    push("if_req", 16'h04);        cmp(16'(if_q));
    push("irq_pending", 16'h1);    cmp(16'(irq_pending));
    push("if_rd", 16'h00E4);       cmp(16'(cpu_rdata));
    bus(16'hFF0F, 8'h00, 1'b1, 5'h01);
    bus(16'hFF0F, 8'h00, 1'b0, 5'h00);
    push("if_race", 16'h01);       cmp(16'(if_q));
    push("if_race_rd", 16'h00E1);  cmp(16'(cpu_rdata));

    // External pass-through write.
    bus(16'h2000, 8'h3C, 1'b1, 5'h00);
    push("ext_we", 16'h1);         cmp(16'(ext_we));
    push("ext_addr", 16'h2000);    cmp(ext_addr);
    push("ext_wdata", 16'h003C);   cmp(16'(ext_wdata));

    // Full DMA from C100 with CPU traffic in the middle.
    bus(16'hFF46, 8'hC1, 1'b1, 5'h00);
    for (int i = 0; i < 160; i++) begin
      if (i == 5) begin
        bus(16'h0150, 8'h00, 1'b0, 5'h00);
        push("dma_ext_rd", 16'h00FF); cmp(16'(cpu_rdata));
      end else if (i == 6) begin
        bus(16'hFF80, 8'h00, 1'b0, 5'h00);
        push("dma_hram_rd", 16'h005A); cmp(16'(cpu_rdata));
      end else if (i == 7) begin
        bus(16'h2000, 8'h77, 1'b1, 5'h00);
        push("dma_ext_we", 16'h0);     cmp(16'(ext_we));
      end else begin
        bus(16'h0000, 8'h00, 1'b0, 5'h00);
      end
      push("dma_oam_we", 16'h1);                cmp(16'(oam_we));
      push("dma_oam_addr", 16'(i));             cmp(16'(oam_addr));
      push("dma_ext_addr", 16'hC100 + 16'(i));  cmp(ext_addr);
      push("dma_oam_wdata", 16'(i));            cmp(16'(oam_wdata));
    end
    bus(16'hFF46, 8'h00, 1'b0, 5'h00);
    push("dma_done", 16'h0);       cmp(16'(dma_active));
    push("dma_done_we", 16'h0);    cmp(16'(oam_we));
    push("dma_reg_rd", 16'h00C1);  cmp(16'(cpu_rdata));

    // Echo-region source folds onto WRAM.
    bus(16'hFF46, 8'hFE, 1'b1, 5'h00);
    bus(16'h0000, 8'h00, 1'b0, 5'h00);
    push("echo_addr0", 16'hDE00);  cmp(ext_addr);
    bus(16'hFF46, 8'h00, 1'b0, 5'h00);
    push("echo_addr1", 16'hDE01);  cmp(ext_addr);
    push("echo_reg_rd", 16'h00FE); cmp(16'(cpu_rdata));
    n = 0;
    while (dma_active && n < 300) begin
      bus(16'h0000, 8'h00, 1'b0, 5'h00);
      n++;
    end
    push("echo_done", 16'h0);      cmp(16'(dma_active));

    // Restart at idx 10, then reset at idx 50.
    bus(16'hFF46, 8'hC1, 1'b1, 5'h00);
    for (int i = 0; i <= 10; i++) begin
      if (i == 10) bus(16'hFF46, 8'hC2, 1'b1, 5'h00);
      else         bus(16'h0000, 8'h00, 1'b0, 5'h00);
      push("rs_c1_addr", 16'hC100 + 16'(i)); cmp(ext_addr);
    end
    for (int i = 0; i <= 50; i++) begin
      bus(16'h0000, 8'h00, 1'b0, 5'h00);
      push("rs_c2_addr", 16'hC200 + 16'(i)); cmp(ext_addr);
      push("rs_c2_idx", 16'(i));             cmp(16'(oam_addr));
      push("rs_c2_we", 16'h1);               cmp(16'(oam_we));
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    push("abort_we_now", 16'h0);   cmp(16'(oam_we));
    push("abort_act_now", 16'h0);  cmp(16'(dma_active));
    @(negedge clk);
    rst       = 1'b1;
    cpu_addr  = 16'h0050;
    cpu_write = 1'b0;
    #2;
    push("abort_we", 16'h0);       cmp(16'(oam_we));
    push("abort_act", 16'h0);      cmp(16'(dma_active));
    push("abort_ext_addr", 16'h0050); cmp(ext_addr);
    push("rerst_if", 16'h00);      cmp(16'(if_q));
    push("rerst_boot", 16'h00AF);  cmp(16'(cpu_rdata));
    bus(16'h0000, 8'h00, 1'b0, 5'h00);
    push("abort_stay", 16'h0);     cmp(16'(oam_we));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
